// File: rtl/fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fifo_ctrl
// Purpose  : Push/pop controller for a true_dpram_sclk-backed FIFO. It drives
//            the RAM ports and tracks occupancy, status flags, sticky errors
//            and read-data-valid timing.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_ctrl #(
  parameter int DATA_W = 10,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  input  logic [ADDR_W:0]   af_thresh_in,
  input  logic [ADDR_W:0]   ae_thresh_in,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] ram_data,
  output logic [ADDR_W-1:0] ram_addr_wa,
  output logic [ADDR_W-1:0] ram_addr_ra,
  output logic              ram_we,
  output logic              ram_re,
  output logic              ram_state,
  output logic [ADDR_W:0]   count,
  output logic              fifo_full,
  output logic              fifo_empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow_err,
  output logic              underflow_err,
  output logic              rd_valid,
  output logic [1:0]        ctrl_state
);

  // Occupancy is one bit wider than the pointers so that DEPTH itself fits.
  localparam logic [ADDR_W:0] c_depth      = (ADDR_W+1)'(2**ADDR_W);
  localparam logic [ADDR_W:0] c_af_default = (ADDR_W+1)'(2**ADDR_W - 2);
  localparam logic [ADDR_W:0] c_ae_default = (ADDR_W+1)'(2);

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_INIT   = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_ERROR  = 2'd3
  } state_t;

  state_t             r_state;
  logic [ADDR_W-1:0]  r_wr_ptr;
  logic [ADDR_W-1:0]  r_rd_ptr;
  logic [ADDR_W:0]    r_count;
  logic [ADDR_W:0]    r_af_th;
  logic [ADDR_W:0]    r_ae_th;
  logic               r_overflow;
  logic               r_underflow;
  logic               r_rd_valid;

  logic               w_active;
  logic               w_push_ok;
  logic               w_pop_ok;

  assign w_active = (r_state == ST_ACTIVE);

  // A push into a full FIFO is legal when a pop frees the slot in the same
  // cycle; a pop from an empty FIFO poisons the whole cycle, push included.
  assign w_push_ok = w_active & push & ~init & (~fifo_full | pop) & ~(pop & fifo_empty);
  assign w_pop_ok  = w_active & pop  & ~init & ~fifo_empty;

  // Status flags derive from the registered occupancy only.
  assign fifo_full    = (r_count == c_depth);
  assign fifo_empty   = (r_count == '0);
  assign almost_full  = (r_count >= r_af_th);
  assign almost_empty = (r_count <= r_ae_th);

  // RAM port drive; outside ACTIVE both enables are low and state is 0.
  assign ram_we      = w_push_ok;
  assign ram_addr_wa = r_wr_ptr;
  assign ram_data    = data_in;
  assign ram_re      = w_pop_ok;
  assign ram_addr_ra = r_rd_ptr;
  assign ram_state   = w_active;

  assign count         = r_count;
  assign overflow_err  = r_overflow;
  assign underflow_err = r_underflow;
  assign rd_valid      = r_rd_valid & w_active;
  assign ctrl_state    = r_state;

  // Controller FSM with pointer, occupancy, threshold and error registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_RESET;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_af_th     <= c_af_default;
      r_ae_th     <= c_ae_default;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_rd_valid  <= 1'b0;
    end else begin
      // RAM q_a holds the popped word one cycle after the read enable.
      r_rd_valid <= w_pop_ok;

      case (r_state)
        ST_RESET: begin
          r_state <= ST_INIT;
        end

        ST_INIT: begin
          // Zero or oversized almost-full thresholds saturate to DEPTH.
          if ((af_thresh_in == '0) || (af_thresh_in > c_depth)) begin
            r_af_th <= c_depth;
          end else begin
            r_af_th <= af_thresh_in;
          end
          // Oversized almost-empty thresholds fall back to 0.
          if (ae_thresh_in > c_depth) begin
            r_ae_th <= '0;
          end else begin
            r_ae_th <= ae_thresh_in;
          end
          r_wr_ptr    <= '0;
          r_rd_ptr    <= '0;
          r_count     <= '0;
          r_overflow  <= 1'b0;
          r_underflow <= 1'b0;
          if (!init) begin
            r_state <= ST_ACTIVE;
          end
        end

        ST_ACTIVE: begin
          if (init) begin
            r_state     <= ST_INIT;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
          end else if (push && fifo_full && !pop) begin
            r_overflow <= 1'b1;
            r_state    <= ST_ERROR;
          end else if (pop && fifo_empty) begin
            r_underflow <= 1'b1;
            r_state     <= ST_ERROR;
          end else begin
            if (w_push_ok) begin
              r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
              r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop_ok})
              2'b10:   r_count <= r_count + 1'b1;
              2'b01:   r_count <= r_count - 1'b1;
              default: r_count <= r_count;
            endcase
          end
        end

        ST_ERROR: begin
          // Everything stays frozen until software re-initialises.
          if (init) begin
            r_state     <= ST_INIT;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
          end
        end

        default: begin
          r_state <= ST_RESET;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_ctrl
// Purpose  : Self-checking bench for fifo_ctrl with a behavioural RAM and a
//            read-data scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_ctrl;

  logic       clk;
  logic       reset;
  logic       init;
  logic [3:0] af_thresh_in;
  logic [3:0] ae_thresh_in;
  logic       push;
  logic       pop;
  logic [9:0] data_in;
  logic [9:0] ram_data;
  logic [2:0] ram_addr_wa;
  logic [2:0] ram_addr_ra;
  logic       ram_we;
  logic       ram_re;
  logic       ram_state;
  logic [3:0] count;
  logic       fifo_full;
  logic       fifo_empty;
  logic       almost_full;
  logic       almost_empty;
  logic       overflow_err;
  logic       underflow_err;
  logic       rd_valid;
  logic [1:0] ctrl_state;

  fifo_ctrl #(.DATA_W(10), .ADDR_W(3)) dut (
    .clk           (clk),
    .reset         (reset),
    .init          (init),
    .af_thresh_in  (af_thresh_in),
    .ae_thresh_in  (ae_thresh_in),
    .push          (push),
    .pop           (pop),
    .data_in       (data_in),
    .ram_data      (ram_data),
    .ram_addr_wa   (ram_addr_wa),
    .ram_addr_ra   (ram_addr_ra),
    .ram_we        (ram_we),
    .ram_re        (ram_re),
    .ram_state     (ram_state),
    .count         (count),
    .fifo_full     (fifo_full),
    .fifo_empty    (fifo_empty),
    .almost_full   (almost_full),
    .almost_empty  (almost_empty),
    .overflow_err  (overflow_err),
    .underflow_err (underflow_err),
    .rd_valid      (rd_valid),
    .ctrl_state    (ctrl_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural read-before-write RAM; q_a reads 0 while state is low.
  logic [9:0] mem [8];
  logic [9:0] q_a;
  always @(posedge clk) begin
    if (ram_state) begin
      if (ram_re) q_a <= mem[ram_addr_ra];
      if (ram_we) mem[ram_addr_wa] <= ram_data;
    end else begin
      q_a <= '0;
    end
  end

  int checks = 0;
  int errors = 0;

  logic [9:0] model_q[$];   // words currently held in the FIFO
  logic [9:0] sb_q[$];      // words expected on q_a after an accepted pop

  typedef struct {
    logic       push;
    logic       pop;
    logic [9:0] data;
    int         exp_wa;
    logic [3:0] exp_count;
    logic       exp_full;
    logic       exp_empty;
    logic       exp_af;
    logic       exp_ae;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: checks enables/addresses, updates the scoreboard, then
  // checks rd_valid and q_a right after the edge.
  task automatic tick(input bit acc_push, input bit acc_pop, input int exp_wa, input int exp_ra);
    logic [9:0] w;
    #1;
    check("ram_we", ram_we, acc_push);
    check("ram_re", ram_re, acc_pop);
    if (exp_wa >= 0) check("ram_addr_wa", ram_addr_wa, exp_wa);
    if (exp_ra >= 0) check("ram_addr_ra", ram_addr_ra, exp_ra);
    if (acc_pop && model_q.size() > 0) sb_q.push_back(model_q.pop_front());
    if (acc_push) model_q.push_back(data_in);
    @(posedge clk);
    #1;
    check("rd_valid", rd_valid, acc_pop);
    if (acc_pop) begin
      if (sb_q.size() > 0) begin
        w = sb_q.pop_front();
        check("q_a", q_a, w);
      end else begin
        checks++;
        errors++;
        $display("FAIL scoreboard: no expected word for pop at %0t", $time);
      end
    end
  endtask

  task automatic init_pulse();
    push = 0; pop = 0; init = 1;
    tick(0, 0, -1, -1);
    check("init_state", ctrl_state, 2'd1);
    check("init_count", count, 4'd0);
    check("init_ovf", overflow_err, 1'b0);
    check("init_udf", underflow_err, 1'b0);
    check("init_empty", fifo_empty, 1'b1);
    model_q.delete();
    sb_q.delete();
    init = 0;
    tick(0, 0, -1, -1);
    check("active_state", ctrl_state, 2'd2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "timeout");
  end

  initial begin
    // Fill sequence with af=6, ae=2: word i+1 goes to address i.
    vecs[0] = '{1'b1, 1'b0, 10'h001, 0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{1'b1, 1'b0, 10'h002, 1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 1'b0, 10'h003, 2, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 10'h004, 3, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 10'h005, 4, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 10'h006, 5, 4'd6, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 10'h007, 6, 4'd7, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 10'h008, 7, 4'd8, 1'b1, 1'b0, 1'b1, 1'b0};

    reset = 1; init = 0; push = 0; pop = 0; data_in = '0;
    af_thresh_in = 4'd6; ae_thresh_in = 4'd2;

    // Reset values, then RESET -> INIT -> ACTIVE.
    #3;
    check("rst_state", ctrl_state, 2'd0);
    check("rst_count", count, 4'd0);
    check("rst_empty", fifo_empty, 1'b1);
    check("rst_ae", almost_empty, 1'b1);
    check("rst_full", fifo_full, 1'b0);
    check("rst_af", almost_full, 1'b0);
    check("rst_ram_state", ram_state, 1'b0);
    @(negedge clk) reset = 0;
    @(posedge clk); #1;
    check("post_rst_state", ctrl_state, 2'd1);
    @(posedge clk); #1;
    check("active_state0", ctrl_state, 2'd2);

    // Table-driven fill of eight words.
    for (int i = 0; i < 8; i++) begin
      push = vecs[i].push; pop = vecs[i].pop; data_in = vecs[i].data;
      tick(vecs[i].push, vecs[i].pop, vecs[i].exp_wa, -1);
      check("fill_count", count, vecs[i].exp_count);
      check("fill_full", fifo_full, vecs[i].exp_full);
      check("fill_empty", fifo_empty, vecs[i].exp_empty);
      check("fill_af", almost_full, vecs[i].exp_af);
      check("fill_ae", almost_empty, vecs[i].exp_ae);
    end

    // Full: simultaneous push/pop, read-before-write at address 0.
    push = 1; pop = 1; data_in = 10'h3FF;
    tick(1, 1, 0, 0);
    check("fullpp_count", count, 4'd8);
    check("fullpp_mem0", mem[0], 10'h3FF);

    // Full: push alone overflows and freezes.
    push = 1; pop = 0; data_in = 10'h2AA;
    tick(0, 0, -1, -1);
    check("ovf_flag", overflow_err, 1'b1);
    check("ovf_state", ctrl_state, 2'd3);
    check("ovf_ram_state", ram_state, 1'b0);
    check("ovf_count", count, 4'd8);
    push = 1; pop = 1;
    tick(0, 0, -1, -1);
    check("err_frozen_count", count, 4'd8);
    check("err_frozen_state", ctrl_state, 2'd3);
    init_pulse();

    // Empty: push and pop together underflows.
    push = 1; pop = 1; data_in = 10'h155;
    tick(0, 0, -1, -1);
    check("udf_flag", underflow_err, 1'b1);
    check("udf_state", ctrl_state, 2'd3);
    check("udf_count", count, 4'd0);
    check("udf_ovf", overflow_err, 1'b0);
    init_pulse();

    // Wrap-around with alternating push/pop pairs.
    for (int i = 0; i < 12; i++) begin
      push = 1; pop = 0; data_in = 10'($urandom_range(0, 1023));
      tick(1, 0, i % 8, -1);
      check("wrap_count1", count, 4'd1);
      push = 0; pop = 1;
      tick(0, 1, -1, i % 8);
      check("wrap_count0", count, 4'd0);
    end

    // Asynchronous reset mid-cycle with data in the FIFO.
    push = 1; pop = 0; data_in = 10'h0F0;
    tick(1, 0, 4, -1);
    data_in = 10'h00F;
    tick(1, 0, 5, -1);
    check("pre_rst_count", count, 4'd2);
    push = 0;
    #2;
    reset = 1;
    #1;
    check("arst_state", ctrl_state, 2'd0);
    check("arst_count", count, 4'd0);
    check("arst_empty", fifo_empty, 1'b1);
    check("arst_ae", almost_empty, 1'b1);
    check("arst_ram_state", ram_state, 1'b0);
    check("arst_rd_valid", rd_valid, 1'b0);
    @(negedge clk) reset = 0;
    @(posedge clk); #1;
    check("arst_init", ctrl_state, 2'd1);
    @(posedge clk); #1;
    check("arst_active", ctrl_state, 2'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
Controller that sits directly upstream of the true_dpram_sclk buffer in each transaction-layer FIFO. It accepts push/pop requests and forwards write data. It drives the RAM's write/read addresses, enables and state input. It also keeps occupancy and full/empty/almost flags, reports overflow/underflow errors, and marks when RAM read data is valid.

Parameters:
DATA_W, 10, word width; matches RAM data width
ADDR_W, 3, pointer width; DEPTH = 2**ADDR_W = 8 words

Ports:
clk  in  1  rising-edge clock shared with RAM
reset  in  1  asynchronous, active-high reset
init  in  1  request (re)initialisation; thresholds sampled while in INIT
af_thresh_in  in  ADDR_W+1  almost-full threshold
ae_thresh_in  in  ADDR_W+1  almost-empty threshold
push  in  1  write request
pop  in  1  read request
data_in  in  DATA_W  write data
ram_data  out  DATA_W  to RAM data_a
ram_addr_wa  out  ADDR_W  to RAM addr_wa
ram_addr_ra  out  ADDR_W  to RAM addr_ra
ram_we  out  1  to RAM we_a
ram_re  out  1  to RAM re_a
ram_state  out  1  to RAM state; 1 only in ACTIVE
count  out  ADDR_W+1  occupancy 0..DEPTH
fifo_full, fifo_empty, almost_full, almost_empty  out  1 each  status flags
overflow_err, underflow_err  out  1 each  sticky error flags
rd_valid  out  1  RAM q_a holds popped word this cycle
ctrl_state  out  2  FSM state encoding

Behaviour:
- FSM states: RESET=0, INIT=1, ACTIVE=2, ERROR=3.
- reset asserted (async): state RESET; wr_ptr, rd_ptr and count = 0; af_th = DEPTH-2 (6); ae_th = 2; errors = 0; rd_valid = 0.
- Output values in reset: fifo_empty=1, almost_empty=1, fifo_full=0, almost_full=0, ram_we=0, ram_re=0, ram_state=0.
- RESET -> INIT on first clk edge after reset deasserts.
- INIT: every cycle, latch thresholds.
  - af_thresh_in of 0 or >DEPTH latches as DEPTH.
  - ae_thresh_in >DEPTH latches as 0.
  - Pointers, count and errors are held at 0.
  - If init=0, go to ACTIVE next cycle.
- ACTIVE:
  - init=1 -> INIT. Pointers, count and errors clear on that edge. Requests that cycle are ignored.
  - Otherwise, a push with fifo_full=1 and pop=0 sets overflow_err and goes to ERROR.
  - A pop with fifo_empty=1 sets underflow_err and goes to ERROR, even if push is also high.
  - In either error case, no pointer or count change occurs that cycle.
- ERROR: pointers and count frozen; ram_we=ram_re=0; ram_state=0, so RAM q_a reads 0. Exit only via init=1 -> INIT.
- push_ok = ACTIVE & push & ~init & (~fifo_full | pop) & ~(pop & fifo_empty).
- pop_ok = ACTIVE & pop & ~init & ~fifo_empty.
- RAM drive (combinational):
  - ram_we = push_ok; ram_addr_wa = wr_ptr; ram_data = data_in.
  - ram_re = pop_ok; ram_addr_ra = rd_ptr.
- Pointers: wr_ptr += push_ok; rd_ptr += pop_ok. Modulo DEPTH, natural ADDR_W-bit wrap.
- count: +1 on push_ok only, -1 on pop_ok only, unchanged when both.
- Push and pop together when full: both accepted. wr_ptr equals rd_ptr, and the RAM returns the old word (read-before-write); count stays DEPTH.
- Flags are combinational from registered count:
  - fifo_full = (count==DEPTH); fifo_empty = (count==0).
  - almost_full = (count>=af_th); almost_empty = (count<=ae_th).
- Read latency: rd_valid is pop_ok registered one cycle. It aligns with RAM q_a and is forced 0 in every state except ACTIVE.
- ctrl_state reflects the registered state.

Test Plan:
- Reset pulse mid-cycle -> immediately ctrl_state=0, count=0, fifo_empty=1, almost_empty=1, ram_state=0. After release, one clk gives ctrl_state=1; with init=0, the next clk gives ctrl_state=2.
- In INIT, af=6, ae=2. Push 8 words 0x001..0x008 on consecutive cycles, then:
  - almost_empty drops after count=3.
  - almost_full rises at count=6.
  - fifo_full=1 at count=8.
  - ram_addr_wa sequence is 0..7.
- Full FIFO, push and pop same cycle with data_in=0x3FF -> count stays 8. One cycle later rd_valid=1 and q_a=0x001; 0x3FF is written at address 0.
- Full FIFO, push alone -> overflow_err=1, ctrl_state=3, ram_state=0, count frozen at 8. Pulse init -> INIT; errors clear and count=0.
- Empty FIFO, push and pop together -> underflow_err=1, ctrl_state=3, ram_we=0 that cycle.
- Wrap-around: 12 alternating push/pop pairs -> pointers wrap from 7 to 0. Each popped word equals the word pushed earlier; count never exceeds 1.
